uart_prog_loader: RTL and testbench



---
 rtl/uart_prog_loader.sv | 219 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: 8N1 receiver plus packet parser that turns a byte stream
// (CMD, LEN_LO, LEN_HI, data...) into sequential 32-bit instruction-memory writes.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [7:0]  CMD_BYTE     = 8'h03,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              frame_err_o
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW     = ADDR_W + 1;
  localparam int unsigned MaxCount = 1 << ADDR_W;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StDone} ld_state_e;

  // Receiver state
  logic            sync1_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // Loader state
  ld_state_e         ld_state_q, ld_state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [IdxW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic [15:0]       len_full;
  logic [31:0]       word_next;

  // 2-FF synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      rx_sync_q <= sync1_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next-state: mid-bit sampling, LSB first
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    unique case (rx_state_q)
      RxIdle: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d  = '0;
          // Line back high at mid-start means it was a glitch
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RxStop;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d  = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Receiver registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RxIdle;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign len_full  = {byte_q, len_lo_q};
  assign word_next = {byte_q, word_q[31:8]};

  // Loader next-state: packet parsing and word assembly
  always_comb begin
    ld_state_d = ld_state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    // done follows DONE by one cycle so it rises after the final strobe
    done_d     = done_q | (ld_state_q == StDone);
    if (byte_valid_q) begin
      unique case (ld_state_q)
        StIdle:  if (byte_q == CMD_BYTE) ld_state_d = StLenLo;
        StLenLo: begin
          len_lo_d   = byte_q;
          ld_state_d = StLenHi;
        end
        StLenHi: begin
          if (32'(len_full) > MaxCount) count_d = IdxW'(MaxCount);
          else                          count_d = IdxW'(len_full);
          index_d    = '0;
          byte_cnt_d = '0;
          ld_state_d = (len_full == 16'd0) ? StDone : StData;
        end
        StData: begin
          word_d = word_next;
          if (byte_cnt_q == 2'd3) begin
            wen_d      = 1'b1;
            adr_d      = index_q[ADDR_W-1:0];
            dat_d      = word_next;
            index_d    = index_q + 1'b1;
            byte_cnt_d = '0;
            if (index_q + 1'b1 == count_q) ld_state_d = StDone;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        StDone:  ;
        default: ld_state_d = StIdle;
      endcase
    end
  end

  // Loader registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_state_q <= StIdle;
      len_lo_q   <= '0;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
    end
  end

  assign upg_wen_o   = wen_q;
  assign upg_adr_o   = adr_q;
  assign upg_dat_o   = dat_q;
  assign upg_done_o  = done_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every upg_wen_o strobe.
module tb_uart_prog_loader;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned AddrW = 14;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rx_i  = 1'b1;
  logic             upg_wen_o;
  logic [AddrW-1:0] upg_adr_o;
  logic [31:0]      upg_dat_o;
  logic             upg_done_o;
  logic             frame_err_o;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        last;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic pend_last = 1'b0;

  uart_prog_loader #(
    .CLKS_PER_BIT(Cpb),
    .CMD_BYTE    (8'h03),
    .ADDR_W      (AddrW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_i       (rx_i),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clock) begin
    wr_t e;
    if (pend_last) begin
      chk("done_after_last", 32'(upg_done_o), 32'd1);
      pend_last = 1'b0;
    end
    if (upg_wen_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr=%0h dat=%08h expected no write",
                 upg_adr_o, upg_dat_o);
      end else begin
        e = sb.pop_front();
        chk("wr_adr", 32'(upg_adr_o), e.adr);
        chk("wr_dat", upg_dat_o, e.dat);
        chk("done_during_write", 32'(upg_done_o), 32'd0);
        pend_last = e.last;
      end
    end
  end

  task automatic drive_bit(input logic v);
    @(negedge clock);
    rx_i = v;
    repeat (Cpb - 1) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic expect_wr(input logic [31:0] adr, input logic [31:0] dat, input logic last);
    wr_t e;
    e.adr  = adr;
    e.dat  = dat;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic settle_and_check_empty(input string name);
    repeat (16) @(negedge clock);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_wen", 32'(upg_wen_o), 32'd0);
    chk("rst_adr", 32'(upg_adr_o), 32'd0);
    chk("rst_dat", upg_dat_o, 32'd0);
    chk("rst_done", 32'(upg_done_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    do_reset();

    // Scenario 1: two-word image
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
    expect_wr(32'd0, 32'h12345678, 1'b0);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    expect_wr(32'd1, 32'hDEADBEEF, 1'b1);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    settle_and_check_empty("s1_all_writes");
    chk("s1_done", 32'(upg_done_o), 32'd1);
    chk("s1_ferr", 32'(frame_err_o), 32'd0);

    // Scenario 2: junk byte ignored, zero-length image
    do_reset();
    send_byte(8'h55); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    settle_and_check_empty("s2_no_writes");
    chk("s2_done", 32'(upg_done_o), 32'd1);

    // Scenario 3: one-cycle glitch, then a one-word image
    do_reset();
    @(negedge clock); rx_i = 1'b0;
    @(negedge clock); rx_i = 1'b1;
    repeat (40) @(negedge clock);
    chk("s3_glitch_done", 32'(upg_done_o), 32'd0);
    chk("s3_glitch_ferr", 32'(frame_err_o), 32'd0);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    expect_wr(32'd0, 32'hDDCCBBAA, 1'b1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    settle_and_check_empty("s3_all_writes");
    chk("s3_done", 32'(upg_done_o), 32'd1);

    // Scenario 4: framing error inside DATA drops the byte
    do_reset();
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hFF, 1'b0);
    repeat (8) @(negedge clock);
    chk("s4_ferr", 32'(frame_err_o), 32'd1);
    chk("s4_done_mid", 32'(upg_done_o), 32'd0);
    expect_wr(32'd0, 32'h04030201, 1'b1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    settle_and_check_empty("s4_all_writes");
    chk("s4_done", 32'(upg_done_o), 32'd1);

    // Scenario 5: reset mid-word, then a fresh packet
    do_reset();
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("s5_rst_wen", 32'(upg_wen_o), 32'd0);
    chk("s5_rst_adr", 32'(upg_adr_o), 32'd0);
    chk("s5_rst_dat", upg_dat_o, 32'd0);
    chk("s5_rst_done", 32'(upg_done_o), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    expect_wr(32'd0, 32'h44332211, 1'b1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    settle_and_check_empty("s5_all_writes");
    chk("s5_done", 32'(upg_done_o), 32'd1);

    // Scenario 6: packets after DONE are ignored
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    settle_and_check_empty("s6_no_writes");
    chk("s6_done", 32'(upg_done_o), 32'd1);
    chk("s6_ferr", 32'(frame_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
